// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a runtime-loadable pattern,
// a registered one-cycle match pulse and a saturating match counter.
// Overlapping or non-overlapping detection is chosen per accepted bit.
//
// Input qualification: x is consumed on a rising clk edge only when
// x_valid=1. There is no back-pressure (the detector always accepts), and
// bits presented in a cycle where pat_load=1 are dropped.
//
// The detector's state is the shift history plus a fill count. The
// matched-prefix length derived from them is exported on prog as the
// observable FSM state.
module seq_detect_param #(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1010,
    localparam int              PW          = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             out,
    output logic [PW-1:0]    prog,
    output logic [CNT_W-1:0] match_cnt
);

    // Registered state and next-state values
    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PW-1:0]    fill_q, fill_d;
    logic             out_q,  out_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    // Candidate values if the current bit is accepted
    logic [PAT_W-1:0] h_acc;
    logic [PW-1:0]    f_acc;
    logic             match;

    // Shift candidate, saturating fill candidate and the match decision
    always_comb begin
        h_acc = {hist_q[PAT_W-2:0], x};
        f_acc = (fill_q == PW'(PAT_W)) ? fill_q : fill_q + 1'b1;
        match = x_valid && !pat_load && (f_acc == PW'(PAT_W)) && (h_acc == pat_q);
    end

    // Next-state: pattern load beats an accepted bit, which beats idle
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = h_acc;
            out_d  = match;
            // A non-overlapping match restarts the count of collected bits
            fill_d = (match && !overlap) ? '0 : f_acc;
        end
    end

    // Counter: clear has priority over a same-cycle increment; saturates at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= DEFAULT_PAT;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    // Matched-prefix length: largest k <= fill whose newest k history bits
    // equal the first k pattern bits (pattern MSB is sent first)
    always_comb begin
        prog = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            if ((PW'(k) <= fill_q) &&
                (((hist_q ^ (pat_q >> (PAT_W - k))) & ({PAT_W{1'b1}} >> (PAT_W - k))) == '0)) begin
                prog = PW'(k);
            end
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param. Two instances share all inputs: one
// with the default 8-bit counter and one with a 2-bit counter so that
// saturation can be reached quickly.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       x;
    logic       x_valid;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       clr_cnt;

    logic       out_a, out_b;
    logic [2:0] prog_a, prog_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    seq_detect_param #(.PAT_W(4), .CNT_W(8), .DEFAULT_PAT(4'b1010)) dut_a (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
        .out(out_a), .prog(prog_a), .match_cnt(cnt_a)
    );

    seq_detect_param #(.PAT_W(4), .CNT_W(2), .DEFAULT_PAT(4'b1010)) dut_b (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
        .out(out_b), .prog(prog_b), .match_cnt(cnt_b)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present one accepted bit, then check out/prog of dut_a just after the edge
    task automatic send(input logic b, input logic e_out, input int e_prog, input string tag);
        x       = b;
        x_valid = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        chk({tag, ".out"},  32'(out_a),  32'(e_out));
        chk({tag, ".prog"}, 32'(prog_a), 32'(e_prog));
    endtask

    task automatic idle(input int n);
        x_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] p, input logic xv, input logic xb, input logic clr);
        pat_load = 1'b1;
        pat_in   = p;
        x_valid  = xv;
        x        = xb;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
        x_valid  = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    initial begin
        // Reset block
        rst = 1'b1; x = 1'b0; x_valid = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = 4'b0000; clr_cnt = 1'b0;
        #1;
        chk("rst.out",  32'(out_a),  0);
        chk("rst.prog", 32'(prog_a), 0);
        chk("rst.cnt",  32'(cnt_a),  0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Overlapping detection of 101010 with the default pattern
        overlap = 1'b1;
        send(1, 0, 1, "ov1"); send(0, 0, 2, "ov2"); send(1, 0, 3, "ov3");
        send(0, 1, 4, "ov4"); send(1, 0, 3, "ov5"); send(0, 1, 4, "ov6");
        chk("ov.cnt", 32'(cnt_a), 2);
        idle(1);
        chk("ov.idle_out", 32'(out_a), 0);

        // Non-overlapping detection after reloading the default pattern
        load(4'b1010, 1'b0, 1'b0, 1'b0);
        chk("no.load_prog", 32'(prog_a), 0);
        chk("no.load_cnt",  32'(cnt_a),  2);
        overlap = 1'b0;
        send(1, 0, 1, "no1"); send(0, 0, 2, "no2"); send(1, 0, 3, "no3");
        send(0, 1, 0, "no4"); send(1, 0, 1, "no5"); send(0, 0, 2, "no6");
        chk("no.cnt6", 32'(cnt_a), 3);
        send(1, 0, 3, "no7"); send(0, 1, 0, "no8");
        chk("no.cnt8", 32'(cnt_a), 4);

        // x_valid gap inside a partial match
        load(4'b1010, 1'b0, 1'b0, 1'b0);
        overlap = 1'b1;
        send(1, 0, 1, "gap1"); send(0, 0, 2, "gap2");
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk($sformatf("gap.idle%0d.out", i),  32'(out_a),  0);
            chk($sformatf("gap.idle%0d.prog", i), 32'(prog_a), 2);
        end
        send(1, 0, 3, "gap3"); send(0, 1, 4, "gap4");
        chk("gap.cnt", 32'(cnt_a), 5);

        // Pattern load mid-sequence discards the concurrently presented bit
        load(4'b1010, 1'b0, 1'b0, 1'b0);
        send(1, 0, 1, "pl1"); send(0, 0, 2, "pl2"); send(1, 0, 3, "pl3");
        load(4'b0110, 1'b1, 1'b0, 1'b0);
        chk("pl.load_prog", 32'(prog_a), 0);
        chk("pl.load_out",  32'(out_a),  0);
        send(0, 0, 1, "pl4"); send(1, 0, 2, "pl5"); send(1, 0, 3, "pl6");
        send(0, 1, 4, "pl7");
        chk("pl.cnt", 32'(cnt_a), 6);

        // All-ones pattern, overlapping, 2-bit counter saturation
        load(4'b1111, 1'b0, 1'b0, 1'b1);
        chk("sat.clr_a", 32'(cnt_a), 0);
        chk("sat.clr_b", 32'(cnt_b), 0);
        send(1, 0, 1, "sat1"); send(1, 0, 2, "sat2"); send(1, 0, 3, "sat3");
        send(1, 1, 4, "sat4"); chk("sat4.cnt_b", 32'(cnt_b), 1);
        send(1, 1, 4, "sat5"); chk("sat5.cnt_b", 32'(cnt_b), 2);
        send(1, 1, 4, "sat6"); chk("sat6.cnt_b", 32'(cnt_b), 3);
        send(1, 1, 4, "sat7"); chk("sat7.cnt_b", 32'(cnt_b), 3);
        send(1, 1, 4, "sat8"); chk("sat8.cnt_b", 32'(cnt_b), 3);
        chk("sat.cnt_a", 32'(cnt_a), 5);
        chk("sat.out_b", 32'(out_b), 1);
        clr_cnt = 1'b1;
        send(1, 1, 4, "clr_match");
        clr_cnt = 1'b0;
        chk("clr_match.cnt_a", 32'(cnt_a), 0);
        chk("clr_match.cnt_b", 32'(cnt_b), 0);

        // Asynchronous reset between edges, right after a match
        send(1, 1, 4, "ar1");
        chk("ar1.cnt", 32'(cnt_a), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.out",  32'(out_a),  0);
        chk("ar.prog", 32'(prog_a), 0);
        chk("ar.cnt",  32'(cnt_a),  0);
        #2;
        rst = 1'b0;
        idle(1);
        // Default pattern 1010 is back; non-overlapping run 0,1,0,1,0,1,0
        overlap = 1'b0;
        send(0, 0, 0, "pr1"); send(1, 0, 1, "pr2"); send(0, 0, 2, "pr3");
        send(1, 0, 3, "pr4"); send(0, 1, 0, "pr5"); send(1, 0, 1, "pr6");
        send(0, 0, 2, "pr7");
        chk("pr.cnt", 32'(cnt_a), 1);

        // Report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector: the generalised successor of the team's fixed 4-bit "1010" Moore detector. It accepts one serial bit per qualified clock and compares the most recent PAT_W bits against a runtime-loadable pattern. It raises a registered, Moore-style one-cycle match pulse and keeps a saturating match counter. Overlapping or non-overlapping detection is selectable at run time. It sits between a serial bit source and status/interrupt logic.

## Interface
- PAT_W, 4: pattern length in bits; must be ≥ 2.
- CNT_W, 8: match counter width.
- DEFAULT_PAT, 4'b1010: pattern value after reset, PAT_W bits wide.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  qualifies x; x is sampled only when x_valid=1.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on each accepted bit.
- pat_load  in  1  loads pat_in as the new pattern.
- pat_in  in  PAT_W  new pattern. Bit PAT_W-1 is the first bit of the sequence on the wire.
- clr_cnt  in  1  synchronous clear of match_cnt.
- out  out  1  match pulse, registered.
- prog  out  clog2(PAT_W+1)  current matched-prefix length (the FSM state), 0..PAT_W.
- match_cnt  out  CNT_W  number of matches, saturating.

## Operation
- Internal registers:
  - pat[PAT_W-1:0]
  - hist[PAT_W-1:0] holds the most recent bits, newest in bit 0.
  - fill, range 0..PAT_W: number of valid bits in hist.
- Reset, asynchronous and effective immediately: pat=DEFAULT_PAT, hist=0, fill=0, out=0, match_cnt=0, so prog=0.
- Per-edge priority: pat_load first, then accepted bit (x_valid=1), then idle. clr_cnt is evaluated independently.
- pat_load=1:
  - pat<=pat_in, fill<=0, out<=0.
  - Any x presented with x_valid=1 in that cycle is discarded.
  - match_cnt is unchanged unless clr_cnt=1.
- Accepted bit:
  - h' = {hist[PAT_W-2:0], x} and f' = min(fill+1, PAT_W).
  - match = (f'==PAT_W) && (h'==pat).
  - hist<=h' and out<=match.
  - If match and overlap=0: fill<=0. Otherwise fill<=f'.
  - If match: match_cnt<=match_cnt+1, holding at 2^CNT_W-1 once there.
- Idle cycle (x_valid=0, pat_load=0): hist and fill hold, out<=0.
- clr_cnt=1: match_cnt<=0. This wins over a simultaneous increment, so the result is 0.
- prog is combinational from the registers: the largest k in 0..fill with hist[k-1:0]==pat[PAT_W-1:PAT_W-k] (k=0 always qualifies).
  - After an overlapping match, prog=PAT_W.
  - After a non-overlapping match or a pat_load, prog=0.
- The pattern may be any value, including all-zeros or all-ones. No illegal states exist.

## Timing
- Latency: out is high for exactly the one cycle following the edge that accepted the completing bit. It is never high for two consecutive cycles unless two consecutive accepted bits each complete a match, which is possible with overlap=1 and a periodic pattern.
- match_cnt updates on the same edge that sets out. prog updates on that same edge as well.
- First possible match: the PAT_W-th accepted bit after reset, after a pat_load, or after a non-overlapping match.
- x_valid gaps do not break a partial match. Only accepted bits advance hist.
- rst asserted mid-sequence: out, prog and match_cnt go to 0 without waiting for a clock edge. The first accepted bit after deassertion counts as bit 1.

## Test plan
- Defaults, overlap=1, accepted stream 1,0,1,0,1,0 → out pulses after the 4th and 6th accepted bits; match_cnt=2; prog sequence 1,2,3,4,3,4.
- Same stream with overlap=0 → single pulse after the 4th bit; match_cnt=1; prog after the 6th bit is 2. Stream 1,0,1,0,1,0,1,0 → match_cnt=2.
- Stream 1,0 with x_valid=0 for 3 cycles, then 1,0 → one pulse after the final bit. out stays 0 during the gap.
- After 1,0,1, pulse pat_load with pat_in=4'b0110 while x=0 and x_valid=1 → prog=0, that bit is ignored. Then 0,1,1,0 → pulse, and match_cnt increments from its prior value.
- CNT_W=2, overlap=1, pattern 1111, eight accepted 1s → 5 pulses on consecutive cycles; match_cnt saturates at 3. clr_cnt on the cycle of a match gives match_cnt=0.
- Assert rst asynchronously between edges after 1,0,1 → out=0, prog=0, match_cnt=0 immediately; pattern is back to 1010. Then 0,1,0 → no match, and 1,0,1,0 → one pulse.
